// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready handshake,
// stall/flush, optional 2-entry skid buffer and a saturating flush-drop counter.
module pipe_stage_reg #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
    parameter int                SKID      = 1,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              stall,
    input  logic              flush,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    logic [1:0]        state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;
    logic              main_drop;
    logic              skid_v;
    logic [CNT_W+1:0]  drop_inc;
    logic [CNT_W+1:0]  drop_sum;
    logic [CNT_W-1:0]  drop_nxt;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign skid_v    = (state == FULL);

    // With the skid entry, in_ready depends only on local state, never on out_ready.
    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = (state != FULL) && !stall;
        end else begin : g_noskid
            assign in_ready = (!out_valid || out_ready) && !stall;
        end
    endgenerate

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready && !stall;
    assign main_drop = out_valid && !out_fire;

    assign drop_inc = (CNT_W+2)'(main_drop)
                    + (CNT_W+2)'(skid_v)
                    + (CNT_W+2)'(in_fire);
    assign drop_sum = {2'b00, drop_cnt} + drop_inc;
    assign drop_nxt = (drop_sum > CNT_MAX) ? {CNT_W{1'b1}}
                                           : drop_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            main_q   <= FLUSH_VAL;
            skid_q   <= FLUSH_VAL;
            drop_cnt <= '0;
        end else if (flush) begin
            state    <= EMPTY;
            main_q   <= FLUSH_VAL;
            skid_q   <= FLUSH_VAL;
            drop_cnt <= drop_nxt;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire && SKID != 0) begin
                        skid_q <= in_data;
                        state  <= FULL;
                    end else if (out_fire) begin
                        state  <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule
